// File: rtl/optimsoc_config_responder.sv
// NoC config responder: serves the system configuration words to software.
// Optional CTLIST window enabled by defining OPTIMSOC_CONFIG_CTLIST_EN.
package optimsoc_config_pkg;

  typedef enum logic [1:0] {
    PLAIN    = 2'd0,
    EXTERNAL = 2'd1
  } lmem_style_t;

  typedef struct packed {
    logic [15:0]       NUMTILES;
    logic [15:0]       NUMCTS;
    logic [7:0]        CORES_PER_TILE;
    logic [15:0]       TOTAL_NUM_CORES;
    logic [31:0]       GMEM_SIZE;
    logic [15:0]       GMEM_TILE;
    logic [31:0]       LMEM_SIZE;
    logic [7:0]        NOC_DATA_WIDTH;
    logic              ENABLE_BOOTROM;
    logic              ENABLE_DM;
    logic              ENABLE_PGAS;
    logic              NA_ENABLE_MPSIMPLE;
    logic              NA_ENABLE_DMA;
    logic              NA_DMA_GENIRQ;
    logic              USE_DEBUG;
    logic              DEBUG_STM;
    logic              DEBUG_CTM;
    lmem_style_t       LMEM_STYLE;
    logic [31:0]       DM_BASE;
    logic [31:0]       DM_SIZE;
    logic [31:0]       PGAS_BASE;
    logic [31:0]       PGAS_SIZE;
    logic [7:0]        NA_DMA_ENTRIES;
    logic [15:0]       DEBUG_NUM_MODS;
    logic [63:0][15:0] CTLIST;
  } config_t;

endpackage

module optimsoc_config_responder
  import optimsoc_config_pkg::*;
#(
  parameter config_t CONFIG = '0,
  parameter int      TILEID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [33:0] in_flit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [33:0] out_flit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV_IDX,
    SEND_HDR,
    SEND_DATA,
    DROP
  } state_t;

  localparam logic [4:0] LP_TILE = 5'(TILEID);

  localparam logic [31:0] LP_FLAGS = {
    22'd0,
    (CONFIG.LMEM_STYLE == PLAIN),
    CONFIG.DEBUG_CTM,
    CONFIG.DEBUG_STM,
    CONFIG.USE_DEBUG,
    CONFIG.NA_DMA_GENIRQ,
    CONFIG.NA_ENABLE_DMA,
    CONFIG.NA_ENABLE_MPSIMPLE,
    CONFIG.ENABLE_PGAS,
    CONFIG.ENABLE_DM,
    CONFIG.ENABLE_BOOTROM
  };

  state_t      r_state;
  state_t      w_state_nx;
  logic [4:0]  r_src;
  logic [4:0]  w_src_nx;
  logic [2:0]  r_cls;
  logic [2:0]  w_cls_nx;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_nx;
  logic [33:0] r_out_flit;
  logic [33:0] w_oflit_nx;
  logic        r_out_valid;
  logic        w_ovalid_nx;
  logic        r_err;
  logic        w_err_nx;

  logic        w_in_ready;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_is_pay;
  logic        w_is_last;
  logic        w_is_hdr;
  logic        w_is_single;
  logic [31:0] w_regval;

  assign w_in_ready  = (r_state == IDLE)
                     | (r_state == RECV_IDX)
                     | (r_state == DROP);
  assign w_in_xfer   = in_valid & w_in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;

  assign w_is_pay    = (in_flit[33:32] == 2'b00);
  assign w_is_last   = (in_flit[33:32] == 2'b01);
  assign w_is_hdr    = (in_flit[33:32] == 2'b10);
  assign w_is_single = (in_flit[33:32] == 2'b11);

  assign in_ready  = w_in_ready;
  assign out_flit  = r_out_flit;
  assign out_valid = r_out_valid;
  assign err       = r_err;

`ifdef OPTIMSOC_CONFIG_CTLIST_EN
  logic [7:0] w_ct_off;
  logic [4:0] w_ct_k;
  assign w_ct_off = r_idx - 8'd16;
  assign w_ct_k   = w_ct_off[4:0];
`endif

  always_comb begin
    w_regval = 32'hFFFF_FFFF;
    if (r_idx < 8'd16) begin
      unique case (r_idx[3:0])
        4'd0:  w_regval = 32'(CONFIG.NUMTILES);
        4'd1:  w_regval = 32'(CONFIG.NUMCTS);
        4'd2:  w_regval = 32'(CONFIG.CORES_PER_TILE);
        4'd3:  w_regval = 32'(CONFIG.TOTAL_NUM_CORES);
        4'd4:  w_regval = CONFIG.GMEM_SIZE;
        4'd5:  w_regval = 32'(CONFIG.GMEM_TILE);
        4'd6:  w_regval = CONFIG.LMEM_SIZE;
        4'd7:  w_regval = 32'(CONFIG.NOC_DATA_WIDTH);
        4'd8:  w_regval = LP_FLAGS;
        4'd9:  w_regval = CONFIG.DM_BASE;
        4'd10: w_regval = CONFIG.DM_SIZE;
        4'd11: w_regval = CONFIG.PGAS_BASE;
        4'd12: w_regval = CONFIG.PGAS_SIZE;
        4'd13: w_regval = 32'(CONFIG.NA_DMA_ENTRIES);
        4'd14: w_regval = 32'(CONFIG.DEBUG_NUM_MODS);
        4'd15: w_regval = 32'(TILEID);
      endcase
    end else if (r_idx < 8'd48) begin
`ifdef OPTIMSOC_CONFIG_CTLIST_EN
      w_regval = {CONFIG.CTLIST[{w_ct_k, 1'b1}],
                  CONFIG.CTLIST[{w_ct_k, 1'b0}]};
`else
      w_regval = 32'h0;
`endif
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_src_nx    = r_src;
    w_cls_nx    = r_cls;
    w_idx_nx    = r_idx;
    w_oflit_nx  = r_out_flit;
    w_ovalid_nx = r_out_valid;
    w_err_nx    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          unique case (1'b1)
            w_is_hdr: begin
              w_src_nx   = in_flit[23:19];
              w_cls_nx   = in_flit[26:24];
              w_state_nx = RECV_IDX;
            end
            w_is_single: w_err_nx = 1'b1;
            w_is_pay:    w_err_nx = 1'b0;
            w_is_last:   w_err_nx = 1'b0;
          endcase
        end
      end
      RECV_IDX: begin
        if (w_in_xfer) begin
          unique case (1'b1)
            w_is_last: begin
              w_idx_nx    = in_flit[7:0];
              w_ovalid_nx = 1'b1;
              w_oflit_nx  = {2'b10, r_src, r_cls,
                             LP_TILE, 19'd0};
              w_state_nx  = SEND_HDR;
            end
            w_is_pay: begin
              w_err_nx   = 1'b1;
              w_state_nx = DROP;
            end
            w_is_hdr: begin
              w_err_nx   = 1'b1;
              w_src_nx   = in_flit[23:19];
              w_cls_nx   = in_flit[26:24];
              w_state_nx = RECV_IDX;
            end
            w_is_single: begin
              w_err_nx   = 1'b1;
              w_state_nx = IDLE;
            end
          endcase
        end
      end
      SEND_HDR: begin
        if (w_out_xfer) begin
          w_oflit_nx = {2'b01, w_regval};
          w_state_nx = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (w_out_xfer) begin
          w_ovalid_nx = 1'b0;
          w_state_nx  = IDLE;
        end
      end
      DROP: begin
        if (w_in_xfer && (w_is_last || w_is_single)) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_cls       <= '0;
      r_idx       <= '0;
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_src       <= w_src_nx;
      r_cls       <= w_cls_nx;
      r_idx       <= w_idx_nx;
      r_out_flit  <= w_oflit_nx;
      r_out_valid <= w_ovalid_nx;
      r_err       <= w_err_nx;
    end
  end

endmodule

// File: doc/optimsoc_config_responder.md
OPTIMSOC_CONFIG_RESPONDER -- requirements
Module: optimsoc_config_responder

Interface
REQ-001: Parameter CONFIG, default all-zero config_t, SHALL be the derived system configuration served to software.
REQ-002: Parameter TILEID, default 0, SHALL be the NoC address of this tile, used as the response source field.
REQ-003: Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004: Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005: Port in_flit  input  34  SHALL be the request flit: [33:32] type (00 payload, 01 last, 10 header, 11 single), [31:0] data.
REQ-006: Port in_valid  input  1  SHALL qualify in_flit.
REQ-007: Port in_ready  output  1  SHALL indicate in_flit is accepted this cycle (transfer = in_valid & in_ready).
REQ-008: Port out_flit  output  34  SHALL be the response flit, same format as in_flit.
REQ-009: Port out_valid  output  1  SHALL qualify out_flit.
REQ-010: Port out_ready  input  1  SHALL indicate the NoC accepts out_flit (transfer = out_valid & out_ready).
REQ-011: Port err  output  1  SHALL pulse high for one cycle when a malformed request is discarded.

Function
REQ-012: Header flit fields SHALL be dest [31:27], class [26:24], src [23:19]; other bits zero in responses.
REQ-013: FSM states SHALL be IDLE, RECV_IDX, SEND_HDR, SEND_DATA, DROP.
REQ-014: In IDLE, RECV_IDX and DROP, in_ready SHALL be 1; in SEND_HDR and SEND_DATA, in_ready SHALL be 0.
REQ-015: IDLE: accepted header -> latch src and class, go RECV_IDX; accepted single, payload or last -> discard, stay IDLE, err pulse for single only.
REQ-016: RECV_IDX: accepted last -> latch index = data[7:0], go SEND_HDR; accepted payload -> err pulse, go DROP; accepted header or single -> err pulse, treat as new request start (header -> RECV_IDX with new src/class, single -> IDLE).
REQ-017: DROP: discard flits until an accepted last or single, then go IDLE; no response.
REQ-018: SEND_HDR: out_valid=1, out_flit = {10, dest=latched src, class=latched class, src=TILEID}; on transfer go SEND_DATA.
REQ-019: SEND_DATA: out_valid=1, out_flit = {01, register value}; on transfer go IDLE.
REQ-020: Latency: last request flit accepted in cycle N -> response header valid in cycle N+1; out_flit and out_valid SHALL be registered.
REQ-021: out_flit SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022: Register map (32-bit, zero-extended): 0 NUMTILES, 1 NUMCTS, 2 CORES_PER_TILE, 3 TOTAL_NUM_CORES, 4 GMEM_SIZE, 5 GMEM_TILE, 6 LMEM_SIZE, 7 NOC_DATA_WIDTH, 8 flags, 9 DM_BASE, 10 DM_SIZE, 11 PGAS_BASE, 12 PGAS_SIZE, 13 NA_DMA_ENTRIES, 14 DEBUG_NUM_MODS, 15 TILEID.
REQ-023: Flags word SHALL be bit0 ENABLE_BOOTROM, bit1 ENABLE_DM, bit2 ENABLE_PGAS, bit3 NA_ENABLE_MPSIMPLE, bit4 NA_ENABLE_DMA, bit5 NA_DMA_GENIRQ, bit6 USE_DEBUG, bit7 DEBUG_STM, bit8 DEBUG_CTM, bit9 LMEM_STYLE==PLAIN, others 0.
REQ-024: Index 16..47 SHALL be the CTLIST window (see Configuration); index 48..255 SHALL return 32'hFFFF_FFFF.
REQ-025: err SHALL be 0 in every cycle not named in REQ-015/016.

Reset
REQ-026: rst_n low SHALL immediately force state IDLE, out_valid 0, out_flit 0, err 0, latched src/class/index 0, regardless of in-flight transfer.
REQ-027: After rst_n rises, in_ready SHALL be 1 in the first clock cycle.

Configuration
REQ-028: With OPTIMSOC_CONFIG_CTLIST_EN defined, index 16+k (k 0..31) SHALL return {CTLIST[2k+1], CTLIST[2k]}.
REQ-029: Without OPTIMSOC_CONFIG_CTLIST_EN, index 16..47 SHALL return 32'h0 and no CTLIST multiplexer SHALL be synthesised.

Verification
REQ-030: CONFIG.NUMTILES=16, TILEID=3; header src=5 class=2, then last index 0, out_ready=1 -> header cycle N+1 {10, dest 5, class 2, src 3}, cycle N+2 {01, 32'd16}.
REQ-031: Request index 8 with ENABLE_DM=1, USE_DEBUG=1, LMEM_STYLE=PLAIN, rest 0 -> data 32'h0000_0242; hold out_ready=0 for 5 cycles -> out_flit stable, in_ready 0 throughout.
REQ-032: Header then payload then payload then last -> err pulse on first payload, no response, in_ready=1 throughout, IDLE after last.
REQ-033: CTLIST[4]=16'h0007, CTLIST[5]=16'h0009, request index 18 -> 32'h0009_0007 with macro, 32'h0 without; index 200 -> 32'hFFFF_FFFF.
REQ-034: Assert rst_n low while in SEND_DATA with out_ready=0 -> out_valid 0 same cycle; after release, new request served normally.
REQ-035: Single flit in IDLE -> err pulse, no response; back-to-back two valid requests -> two complete responses in order, none dropped.
